max7000_config_loader: RTL and testbench

Bit-serial configuration loader that sits directly upstream of `altera_max7000` and drives its `bitstream` input. It hunts for a sync word, shifts in exactly `BIT_COUNT` configuration bits into a shadow register, and checks a trailing CRC-16. Only on a CRC match does it commit the shadow image to the device-facing `bitstream` port, so the device model never sees a partial or corrupt configuration.

---
 rtl/max7000_cfg_pkg.sv | 8 +
 rtl/crc16_serial_step.sv | 11 +
 rtl/max7000_config_loader.sv | 85 ++++++++
 tb/tb_max7000_config_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/max7000_cfg_pkg.sv
// max7000_cfg_pkg: shared types and constants for the MAX7000 configuration loader
package max7000_cfg_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, LOAD, CHECK, DONE, ERROR} cfg_state_e;
  localparam logic [31:0] CFG_SYNC_WORD_DEFAULT = 32'hA5C3_0F7E;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam int MAX7000_32MC_BIT_COUNT = 15033;
endpackage

// File: rtl/crc16_serial_step.sv
// crc16_serial_step: one bit of CRC-16-CCITT, MSB-first, no reflection
module crc16_serial_step
  import max7000_cfg_pkg::*;
(
  input  logic [15:0] crc,
  input  logic        din,
  output logic [15:0] crc_next
);
  // shift left and fold in the polynomial when the outgoing bit differs from the data bit
  always_comb crc_next = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
endmodule

// File: rtl/max7000_config_loader.sv
// max7000_config_loader: sync-hunt, shadow load and CRC-gated commit of a MAX7000 bitstream
module max7000_config_loader
  import max7000_cfg_pkg::*;
#(
  parameter int          BIT_COUNT = MAX7000_32MC_BIT_COUNT,
  parameter logic [31:0] SYNC_WORD = CFG_SYNC_WORD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic                 cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic [BIT_COUNT-1:0] bitstream,
  output logic                 config_done,
  output logic                 config_error,
  output logic                 cfg_busy
);
  localparam int CW = $clog2(BIT_COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(BIT_COUNT - 1);
  localparam logic [CW-1:0] CRC_LAST = CW'(15);
  cfg_state_e state;
  logic [30:0] sync_sr;
  logic [14:0] rx_crc;
  logic [CW-1:0] cnt;
  logic [15:0] crc, crc_next;
  logic [BIT_COUNT-1:0] shadow;
  logic xfer;
  crc16_serial_step u_crc (.crc(crc), .din(cfg_data), .crc_next(crc_next));
  // ready and busy decode the current state directly
  always_comb begin
    cfg_ready = state inside {SYNC, LOAD, CHECK};
    cfg_busy  = cfg_ready;
    xfer      = cfg_valid && cfg_ready;
  end
  // loader FSM: sync hunt, data shift into shadow, CRC receive and commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sync_sr      <= '0;
      rx_crc       <= '0;
      cnt          <= '0;
      crc          <= CRC16_INIT;
      shadow       <= '1;
      bitstream    <= '1;
      config_done  <= 1'b0;
      config_error <= 1'b0;
    end else if (cfg_start) begin
      state        <= SYNC;
      sync_sr      <= '0;
      cnt          <= '0;
      crc          <= CRC16_INIT;
      config_done  <= 1'b0;
      config_error <= 1'b0;
    end else if (xfer) begin
      case (state)
        SYNC: begin
          sync_sr <= {sync_sr[29:0], cfg_data};
          if ({sync_sr, cfg_data} == SYNC_WORD) state <= LOAD;
        end
        LOAD: begin
          shadow[LAST - cnt] <= cfg_data;
          crc <= crc_next;
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
          if (cnt == LAST) state <= CHECK;
        end
        CHECK: begin
          rx_crc <= {rx_crc[13:0], cfg_data};
          cnt <= cnt + 1'b1;
          if (cnt == CRC_LAST) begin
            if ({rx_crc, cfg_data} == crc) begin
              state       <= DONE;
              bitstream   <= shadow;
              config_done <= 1'b1;
            end else begin
              state        <= ERROR;
              config_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_max7000_config_loader.sv
// tb_max7000_config_loader: randomized self-checking bench with a stream-level reference model
module tb_max7000_config_loader;
  localparam int BC = 72;
  localparam logic [31:0] SW = 32'hA5C3_0F7E;
  localparam logic [BC-1:0] IMG = 72'h313233343536373839;
  logic clk = 1'b0;
  logic reset, cfg_start, cfg_data, cfg_valid;
  logic cfg_ready, config_done, config_error, cfg_busy;
  logic [BC-1:0] bitstream;
  int n_cmp = 0;
  int n_bad = 0;
  logic [BC-1:0] exp_bs;
  logic q[$];

  max7000_config_loader #(.BIT_COUNT(BC), .SYNC_WORD(SW)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .bitstream(bitstream),
    .config_done(config_done), .config_error(config_error), .cfg_busy(cfg_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // bytewise CRC-16-CCITT over the image, first byte = most significant
  function automatic logic [15:0] crc_ref(input logic [BC-1:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int b = BC / 8 - 1; b >= 0; b--) begin
      c = c ^ {d[b*8 +: 8], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic send_bit(input logic b, input int gap);
    for (int i = 0; i < 20 && $urandom_range(99) < gap; i++) begin
      cfg_valid = 1'b0;
      cfg_data = 1'($urandom);
      @(posedge clk); #1;
    end
    cfg_valid = 1'b1;
    cfg_data = b;
    q.push_back(b);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_word(input logic [127:0] w, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic pulse_start(input logic v);
    cfg_start = 1'b1;
    cfg_valid = v;
    cfg_data = 1'($urandom);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_bs = '1;
    q.delete();
  endtask

  // scan the sent stream for the first sync match, then judge the image that follows it
  task automatic model_and_check(input string tag);
    logic [31:0] w;
    logic [BC-1:0] img;
    logic [15:0] rc;
    logic good;
    int p;
    w = '0;
    p = -1;
    for (int i = 0; i < q.size(); i++) begin
      w = {w[30:0], q[i]};
      if (w == SW) begin
        p = i;
        break;
      end
    end
    if (p >= 0 && q.size() >= p + 1 + BC + 16) begin
      for (int i = 0; i < BC; i++) img[BC-1-i] = q[p+1+i];
      for (int i = 0; i < 16; i++) rc[15-i] = q[p+1+BC+i];
      good = (crc_ref(img) == rc);
      if (good) exp_bs = img;
      chk({tag, "_done"}, config_done, good);
      chk({tag, "_err"}, config_error, !good);
      chk({tag, "_busy"}, cfg_busy, 1'b0);
    end else begin
      chk({tag, "_done"}, config_done, 1'b0);
      chk({tag, "_err"}, config_error, 1'b0);
      chk({tag, "_busy"}, cfg_busy, 1'b1);
    end
    chk({tag, "_bs"}, bitstream, exp_bs);
  endtask

  task automatic load(input string tag, input logic [BC-1:0] img, input logic [15:0] crc,
                      input int noise_n, input logic [31:0] noise, input int gap);
    pulse_start(1'($urandom));
    send_word(noise, noise_n, gap);
    send_word(SW, 32, gap);
    send_word(img, BC, gap);
    send_word(crc, 16, gap);
    model_and_check(tag);
  endtask

  initial begin
    logic [95:0] r;
    logic [BC-1:0] img;
    logic [15:0] c;
    reset = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = 1'b0;
    exp_bs = '1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_bs", bitstream, {BC{1'b1}});
    chk("rst_done", config_done, 1'b0);
    chk("rst_err", config_error, 1'b0);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_busy", cfg_busy, 1'b0);

    load("s2", IMG, 16'h29B1, 0, 0, 0);
    chk("s2_done_lit", config_done, 1'b1);
    chk("s2_bs_lit", bitstream, IMG);
    chk("s2_ready", cfg_ready, 1'b0);

    do_reset();
    load("s3", IMG, 16'h29B0, 0, 0, 0);
    chk("s3_err_lit", config_error, 1'b1);
    chk("s3_bs_lit", bitstream, {BC{1'b1}});

    do_reset();
    load("s4", IMG, 16'h29B1, 8, 32'hA5, 0);
    chk("s4_bs_lit", bitstream, IMG);

    do_reset();
    load("s5", IMG, 16'h29B1, 0, 0, 40);
    chk("s5_bs_lit", bitstream, IMG);
    pulse_start(1'b0);
    chk("s5_restart_done", config_done, 1'b0);
    chk("s5_restart_bs", bitstream, IMG);
    chk("s5_restart_busy", cfg_busy, 1'b1);
    chk("s5_restart_ready", cfg_ready, 1'b1);

    pulse_start(1'b0);
    send_word(SW, 32, 0);
    send_word({56'h0, IMG[71:0]} >> 42, 30, 0);
    chk("s6_abort_busy", cfg_busy, 1'b1);
    load("s6", IMG, 16'h29B1, 0, 0, 0);
    chk("s6_bs_lit", bitstream, IMG);
    pulse_start(1'b0);
    send_word(SW, 32, 0);
    send_word({56'h0, IMG[71:52]}, 20, 0);
    reset = 1'b1;
    #2;
    chk("s6_rst_bs", bitstream, {BC{1'b1}});
    chk("s6_rst_done", config_done, 1'b0);
    chk("s6_rst_busy", cfg_busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_bs = '1;

    for (int t = 0; t < 10; t++) begin
      r = {$urandom, $urandom, $urandom};
      img = r[BC-1:0];
      c = crc_ref(img);
      if ($urandom_range(3) == 0) c = c ^ (16'h1 << $urandom_range(15));
      load($sformatf("rnd%0d", t), img, c, $urandom_range(12), $urandom, $urandom_range(50));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
